// File: rtl/bus_arbiter_rr.sv
// Round-robin arbiter joining serial masters to serial slaves over one shared bus.
// Slave select arrives as a serial address prefix; a stalled transfer can be parked once (split).
module bus_arbiter_rr #(
  parameter int NUM_MASTERS   = 2,
  parameter int NUM_SLAVES    = 3,
  parameter int ADDR_BITS     = 2,
  parameter int SPLIT_TIMEOUT = 12
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_MASTERS-1:0] m_request,
  input  logic [NUM_MASTERS-1:0] m_address_valid,
  input  logic [NUM_MASTERS-1:0] m_address,
  input  logic [NUM_MASTERS-1:0] m_data,
  input  logic [NUM_MASTERS-1:0] m_valid,
  input  logic [NUM_MASTERS-1:0] m_write_en,
  output logic [NUM_MASTERS-1:0] m_grant,
  output logic [NUM_MASTERS-1:0] m_ready,
  output logic [NUM_MASTERS-1:0] m_data_out,
  output logic [NUM_MASTERS-1:0] m_valid_in,
  output logic [NUM_MASTERS-1:0] m_error,
  output logic [NUM_SLAVES-1:0]  s_address,
  output logic [NUM_SLAVES-1:0]  s_data,
  output logic [NUM_SLAVES-1:0]  s_valid,
  output logic [NUM_SLAVES-1:0]  s_write_en,
  output logic [NUM_SLAVES-1:0]  s_bus_ready,
  input  logic [NUM_SLAVES-1:0]  s_data_in,
  input  logic [NUM_SLAVES-1:0]  s_ready,
  input  logic [NUM_SLAVES-1:0]  s_valid_out,
  output logic [2:0]             state,
  output logic                   held
);

  localparam int MW = $clog2(NUM_MASTERS);
  localparam int CW = $clog2(ADDR_BITS + 1);
  localparam int SN = 1 << ADDR_BITS;
  localparam logic [ADDR_BITS:0] NS_LIM = (ADDR_BITS + 1)'(NUM_SLAVES);
  localparam logic [7:0] TO_LIM = 8'(SPLIT_TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ADDR    = 3'd1,
    S_CONNECT = 3'd2,
    S_BUSY    = 3'd3,
    S_SPLIT   = 3'd4
  } state_t;

  state_t                 state_q;
  logic [NUM_MASTERS-1:0] grant_q;
  logic [NUM_MASTERS-1:0] error_q;
  logic [MW-1:0]          gidx_q;
  logic [MW-1:0]          last_q;
  logic                   started_q;
  logic [ADDR_BITS-1:0]   sel_q;
  logic [CW-1:0]          cnt_q;
  logic                   conn_q;
  logic                   held_q;
  logic [MW-1:0]          held_m_q;
  logic [ADDR_BITS-1:0]   held_sel_q;
  logic [7:0]             wait_q;

  function automatic logic [NUM_MASTERS-1:0] onehot(input logic [MW-1:0] idx);
    logic [NUM_MASTERS-1:0] r;
    r      = '0;
    r[idx] = 1'b1;
    return r;
  endfunction

  // Before the first grant the search starts at master 0; afterwards one past the last winner.
  function automatic logic [MW:0] rr_pick(input logic [NUM_MASTERS-1:0] elig,
                                          input logic [MW-1:0] last, input logic started);
    logic          found;
    logic [MW-1:0] win;
    int            start;
    int            i;
    found = 1'b0;
    win   = '0;
    start = started ? int'(last) + 1 : 0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      i = (start + k) % NUM_MASTERS;
      if (!found && elig[i]) begin
        found = 1'b1;
        win   = MW'(i);
      end
    end
    return {found, win};
  endfunction

  logic [NUM_MASTERS-1:0] g_dec;
  logic [MW:0]            idle_pick;
  logic [MW:0]            split_pick;
  logic [SN-1:0]          s_ready_pad;
  logic [SN-1:0]          s_data_in_pad;
  logic [SN-1:0]          s_valid_out_pad;
  logic                   sel_ok;
  logic                   slave_rdy;
  logic                   held_live;
  logic                   others_req;

  assign g_dec           = onehot(gidx_q);
  assign idle_pick       = rr_pick(m_request & m_address_valid, last_q, started_q);
  assign split_pick      = rr_pick(m_request & ~g_dec, last_q, started_q);
  assign s_ready_pad     = SN'(s_ready);
  assign s_data_in_pad   = SN'(s_data_in);
  assign s_valid_out_pad = SN'(s_valid_out);
  assign sel_ok          = {1'b0, sel_q} < NS_LIM;
  assign slave_rdy       = sel_ok & s_ready_pad[sel_q];
  assign held_live       = held_q & m_request[held_m_q];
  assign others_req      = |(m_request & ~g_dec);

  assign m_grant = grant_q;
  assign m_error = error_q;
  assign state   = state_q;
  assign held    = held_q;

  // Routing is driven only by the registered connection, so it never exists outside BUSY.
  always_comb begin
    s_address   = '0;
    s_data      = '0;
    s_valid     = '0;
    s_write_en  = '0;
    s_bus_ready = '1;
    m_ready     = '0;
    m_data_out  = '0;
    m_valid_in  = '0;
    for (int j = 0; j < NUM_SLAVES; j++) begin
      if (conn_q && sel_q == ADDR_BITS'(j)) begin
        s_address[j]  = m_address[gidx_q];
        s_data[j]     = m_data[gidx_q];
        s_valid[j]    = m_valid[gidx_q];
        s_write_en[j] = m_write_en[gidx_q];
      end else if (conn_q) begin
        s_bus_ready[j] = 1'b0;
      end
    end
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (conn_q && gidx_q == MW'(i)) begin
        m_ready[i]    = s_ready_pad[sel_q];
        m_data_out[i] = s_data_in_pad[sel_q];
        m_valid_in[i] = s_valid_out_pad[sel_q];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      grant_q    <= '0;
      error_q    <= '0;
      gidx_q     <= '0;
      last_q     <= '0;
      started_q  <= 1'b0;
      sel_q      <= '0;
      cnt_q      <= '0;
      conn_q     <= 1'b0;
      held_q     <= 1'b0;
      held_m_q   <= '0;
      held_sel_q <= '0;
      wait_q     <= '0;
    end else begin
      error_q <= '0;
      if (held_q && !m_request[held_m_q]) held_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (held_live) begin
            grant_q <= onehot(held_m_q);
            gidx_q  <= held_m_q;
            sel_q   <= held_sel_q;
            held_q  <= 1'b0;
            state_q <= S_CONNECT;
          end else if (idle_pick[MW]) begin
            grant_q   <= onehot(idle_pick[MW-1:0]);
            gidx_q    <= idle_pick[MW-1:0];
            last_q    <= idle_pick[MW-1:0];
            started_q <= 1'b1;
            sel_q     <= '0;
            cnt_q     <= '0;
            state_q   <= S_ADDR;
          end
        end
        S_ADDR: begin
          if (m_valid[gidx_q]) begin
            sel_q <= ADDR_BITS'({sel_q, m_address[gidx_q]});
            if (cnt_q == CW'(ADDR_BITS - 1)) state_q <= S_CONNECT;
            else                             cnt_q   <= cnt_q + 1'b1;
          end
        end
        S_CONNECT: begin
          if (!sel_ok) begin
            error_q <= g_dec;
            grant_q <= '0;
            state_q <= S_IDLE;
          end else if (slave_rdy) begin
            conn_q  <= 1'b1;
            wait_q  <= '0;
            state_q <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (!m_request[gidx_q]) begin
            conn_q <= 1'b0;
            wait_q <= '0;
            if (held_live) begin
              grant_q <= onehot(held_m_q);
              gidx_q  <= held_m_q;
              sel_q   <= held_sel_q;
              held_q  <= 1'b0;
              state_q <= S_CONNECT;
            end else begin
              grant_q <= '0;
              state_q <= S_IDLE;
            end
          end else if (wait_q >= TO_LIM && !held_q && others_req) begin
            conn_q  <= 1'b0;
            grant_q <= '0;
            wait_q  <= '0;
            state_q <= S_SPLIT;
          end else if (m_address_valid[gidx_q]) begin
            conn_q  <= 1'b0;
            wait_q  <= '0;
            sel_q   <= '0;
            cnt_q   <= '0;
            state_q <= S_ADDR;
          end else if (!slave_rdy) begin
            if (wait_q != 8'hFF) wait_q <= wait_q + 8'd1;
          end else begin
            wait_q <= '0;
          end
        end
        S_SPLIT: begin
          // gidx_q and sel_q still describe the stalled transfer being parked.
          held_m_q   <= gidx_q;
          held_sel_q <= sel_q;
          if (split_pick[MW]) begin
            held_q  <= 1'b1;
            grant_q <= onehot(split_pick[MW-1:0]);
            gidx_q  <= split_pick[MW-1:0];
            last_q  <= split_pick[MW-1:0];
            sel_q   <= '0;
            cnt_q   <= '0;
            state_q <= S_ADDR;
          end else begin
            grant_q <= g_dec;
            state_q <= S_CONNECT;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Bench for bus_arbiter_rr: directed transaction table, random transactions against a
// transaction-level round-robin model, plus split and asynchronous reset sequences.
module tb_bus_arbiter_rr;
  localparam int NM = 4;
  localparam int NS = 3;
  localparam int AB = 2;
  localparam int TO = 12;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [NM-1:0] m_request = '0, m_address_valid = '0, m_address = '0;
  logic [NM-1:0] m_data = '0, m_valid = '0, m_write_en = '0;
  logic [NM-1:0] m_grant, m_ready, m_data_out, m_valid_in, m_error;
  logic [NS-1:0] s_address, s_data, s_valid, s_write_en, s_bus_ready;
  logic [NS-1:0] s_data_in = '0, s_ready = '0, s_valid_out = '0;
  logic [2:0]    state;
  logic          held;

  bus_arbiter_rr #(.NUM_MASTERS(NM), .NUM_SLAVES(NS), .ADDR_BITS(AB), .SPLIT_TIMEOUT(TO)) u_dut (
    .clk(clk), .reset(reset),
    .m_request(m_request), .m_address_valid(m_address_valid), .m_address(m_address),
    .m_data(m_data), .m_valid(m_valid), .m_write_en(m_write_en),
    .m_grant(m_grant), .m_ready(m_ready), .m_data_out(m_data_out),
    .m_valid_in(m_valid_in), .m_error(m_error),
    .s_address(s_address), .s_data(s_data), .s_valid(s_valid), .s_write_en(s_write_en),
    .s_bus_ready(s_bus_ready), .s_data_in(s_data_in), .s_ready(s_ready),
    .s_valid_out(s_valid_out), .state(state), .held(held)
  );

  always #5 clk = ~clk;

  int          errors = 0;
  int          checks = 0;
  logic [1:0]  exp_q[$];
  logic [3:0]  pend = '0;
  logic [1:0]  addr_of[NM];
  int          last_m = -1;

  typedef struct {
    logic [3:0]      add;
    logic [3:0][1:0] adr;
    int              exp_g;
    logic            exp_err;
  } vec_t;
  vec_t tab[11];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Rotating priority: first pending master after the previous winner; -1 means none yet.
  function automatic int model_pick(input logic [3:0] p, input int last);
    for (int k = 0; k < NM; k++) begin
      int i;
      i = (last + 1 + k) % NM;
      if (p[i]) return i;
    end
    return -1;
  endfunction

  task automatic add(input logic [3:0] mask, input logic [3:0][1:0] adr);
    for (int i = 0; i < NM; i++) begin
      if (mask[i]) begin
        pend[i]    = 1'b1;
        addr_of[i] = adr[i];
      end
    end
    m_request       = pend;
    m_address_valid = m_address_valid | mask;
  endtask

  task automatic wait_grant(output int g);
    int n;
    int pk;
    n  = 0;
    pk = model_pick(pend, last_m);
    exp_q.push_back(2'(pk));
    do begin
      tick();
      n++;
    end while (m_grant == '0 && n < 20);
    check("grant_seen", 32'(m_grant != '0), 1);
    g = 0;
    for (int i = 0; i < NM; i++) if (m_grant[i]) g = i;
    check("grant_rr", g, exp_q.pop_front());
    check("state_addr", state, 1);
    last_m             = pk;
    m_address_valid[g] = 1'b0;
  endtask

  task automatic send_addr(input int g);
    for (int b = AB - 1; b >= 0; b--) begin
      if ($urandom_range(0, 2) == 0) begin
        m_valid[g] = 1'b0;
        tick();
      end
      m_address[g] = addr_of[g][b];
      m_valid[g]   = 1'b1;
      if (b == 0) check("s_valid_in_addr", s_valid, 0);
      tick();
    end
    m_valid[g] = 1'b0;
    check("state_connect", state, 2);
  endtask

  task automatic connect(input int g, input int cdelay);
    int s;
    s = int'(addr_of[g]);
    for (int d = 0; d < cdelay; d++) begin
      tick();
      check("connect_wait", state, 2);
    end
    s_ready[s] = 1'b1;
    tick();
    check("state_busy", state, 3);
    check("bus_ready_conn", s_bus_ready, 1 << s);
    check("grant_hold", m_grant, 1 << g);
  endtask

  task automatic route(input int g);
    int s;
    logic [NS-1:0] e_d, e_v, e_w, e_a;
    logic [NM-1:0] e_md, e_mv;
    s = int'(addr_of[g]);
    m_data       = NM'($urandom);
    m_write_en   = NM'($urandom);
    m_address[g] = 1'($urandom);
    m_valid[g]   = 1'b1;
    s_data_in    = NS'($urandom);
    s_valid_out  = NS'($urandom);
    #1;
    e_d = '0; e_v = '0; e_w = '0; e_a = '0; e_md = '0; e_mv = '0;
    e_d[s]  = m_data[g];
    e_v[s]  = 1'b1;
    e_w[s]  = m_write_en[g];
    e_a[s]  = m_address[g];
    e_md[g] = s_data_in[s];
    e_mv[g] = s_valid_out[s];
    check("route_s_data", s_data, e_d);
    check("route_s_valid", s_valid, e_v);
    check("route_s_write_en", s_write_en, e_w);
    check("route_s_address", s_address, e_a);
    check("route_m_data_out", m_data_out, e_md);
    check("route_m_valid_in", m_valid_in, e_mv);
    check("route_m_ready", m_ready, 1 << g);
    tick();
  endtask

  task automatic release_bus(input int g);
    m_request[g] = 1'b0;
    pend[g]      = 1'b0;
    m_valid      = '0;
    tick();
    check("release_state", state, 0);
    check("release_grant", m_grant, 0);
    check("release_bus_ready", s_bus_ready, 3'b111);
    s_ready     = '0;
    s_data_in   = '0;
    s_valid_out = '0;
  endtask

  task automatic do_txn(input int cdelay, output int g, output logic err);
    logic [NM-1:0] av;
    wait_grant(g);
    send_addr(g);
    if (int'(addr_of[g]) >= NS) begin
      err = 1'b1;
      tick();
      check("error_pulse", m_error, 1 << g);
      check("error_grant", m_grant, 0);
      check("error_state", state, 0);
      m_request[g] = 1'b0;
      pend[g]      = 1'b0;
      av           = m_address_valid;
      m_address_valid = '0;
      tick();
      check("error_one_cycle", m_error, 0);
      check("error_no_s_valid", s_valid, 0);
      m_address_valid = av;
    end else begin
      err = 1'b0;
      connect(g, cdelay);
      route(g);
      route(g);
      release_bus(g);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1);
  end

  initial begin
    int   g;
    int   n;
    int   pk;
    logic err;

    tab[0]  = '{add: 4'b0011, adr: {2'd0, 2'd0, 2'd2, 2'd1}, exp_g: 0, exp_err: 1'b0};
    tab[1]  = '{add: 4'b0000, adr: {2'd0, 2'd0, 2'd0, 2'd0}, exp_g: 1, exp_err: 1'b0};
    tab[2]  = '{add: 4'b0001, adr: {2'd0, 2'd0, 2'd0, 2'd1}, exp_g: 0, exp_err: 1'b0};
    tab[3]  = '{add: 4'b1111, adr: {2'd0, 2'd2, 2'd1, 2'd0}, exp_g: 1, exp_err: 1'b0};
    tab[4]  = '{add: 4'b0010, adr: {2'd0, 2'd0, 2'd2, 2'd0}, exp_g: 2, exp_err: 1'b0};
    tab[5]  = '{add: 4'b0100, adr: {2'd0, 2'd3, 2'd0, 2'd0}, exp_g: 3, exp_err: 1'b0};
    tab[6]  = '{add: 4'b1000, adr: {2'd1, 2'd0, 2'd0, 2'd0}, exp_g: 0, exp_err: 1'b0};
    tab[7]  = '{add: 4'b0001, adr: {2'd0, 2'd0, 2'd0, 2'd2}, exp_g: 1, exp_err: 1'b0};
    tab[8]  = '{add: 4'b0000, adr: {2'd0, 2'd0, 2'd0, 2'd0}, exp_g: 2, exp_err: 1'b1};
    tab[9]  = '{add: 4'b0000, adr: {2'd0, 2'd0, 2'd0, 2'd0}, exp_g: 3, exp_err: 1'b0};
    tab[10] = '{add: 4'b0000, adr: {2'd0, 2'd0, 2'd0, 2'd0}, exp_g: 0, exp_err: 1'b0};
    for (int i = 0; i < NM; i++) addr_of[i] = '0;

    // Reset state
    #12;
    check("rst_state", state, 0);
    check("rst_grant", m_grant, 0);
    check("rst_error", m_error, 0);
    check("rst_held", held, 0);
    check("rst_bus_ready", s_bus_ready, 3'b111);
    check("rst_s_valid", s_valid, 0);
    @(negedge clk);
    reset = 1'b1;
    tick();

    // Directed rounds: first round also waits 5 cycles for a not-ready slave
    for (int r = 0; r < 11; r++) begin
      add(tab[r].add, tab[r].adr);
      do_txn((r == 0) ? 5 : 0, g, err);
      check("tab_grant", g, tab[r].exp_g);
      check("tab_err", 32'(err), 32'(tab[r].exp_err));
    end

    // Random transactions against the round-robin model
    for (int r = 0; r < 30; r++) begin
      logic [3:0] nm;
      nm = 4'($urandom_range(0, 15)) & ~pend;
      if ((pend | nm) == '0) nm = 4'(1 << $urandom_range(0, NM - 1));
      add(nm, 8'($urandom));
      do_txn($urandom_range(0, 3), g, err);
    end
    for (int k = 0; k < NM && pend != '0; k++) do_txn(0, g, err);

    // Split: M0 stalls on slave 0 while M1 waits for slave 2
    add(4'b0001, {2'd0, 2'd0, 2'd0, 2'd0});
    wait_grant(g);
    send_addr(g);
    connect(g, 0);
    add(4'b0010, {2'd0, 2'd0, 2'd2, 2'd0});
    s_ready[0] = 1'b0;
    s_ready[2] = 1'b1;
    n = 0;
    do begin
      tick();
      n++;
    end while (state != 3'd4 && n < 30);
    check("split_after_timeout", n, TO + 1);
    check("split_grant_off", m_grant, 0);
    pk = model_pick(pend & ~4'b0001, last_m);
    tick();
    check("split_state_addr", state, 1);
    check("split_held", held, 1);
    check("split_rr_grant", m_grant, 1 << pk);
    last_m = pk;
    m_address_valid[1] = 1'b0;
    send_addr(1);
    connect(1, 0);
    route(1);
    check("parked_no_grant", m_grant[0], 0);
    check("parked_held", held, 1);
    s_ready[0]   = 1'b1;
    m_request[1] = 1'b0;
    pend[1]      = 1'b0;
    m_valid      = '0;
    n = 0;
    do begin
      tick();
      n++;
    end while (!(state == 3'd3 && m_grant == 4'b0001) && n < 10);
    check("reconnect_cycles", n, 2);
    check("reconnect_bus_ready", s_bus_ready, 3'b001);
    check("reconnect_held_clear", held, 0);

    // Asynchronous reset between edges while M0 is routed to slave 0
    m_data[0]  = 1'b1;
    m_valid[0] = 1'b1;
    #1;
    check("pre_reset_route", s_data, 3'b001);
    @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    check("areset_state", state, 0);
    check("areset_grant", m_grant, 0);
    check("areset_bus_ready", s_bus_ready, 3'b111);
    check("areset_s_data", s_data, 0);
    check("areset_m_ready", m_ready, 0);
    check("areset_held", held, 0);
    m_request = '0;
    m_valid   = '0;
    m_data    = '0;
    s_ready   = '0;
    @(negedge clk);
    reset = 1'b1;
    tick();
    check("post_reset_idle", state, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bus_arbiter_rr.md
Name: bus_arbiter_rr

Overview:
- Parametrised successor to the 2-master/3-slave serial bus arbiter.
- Connects NUM_MASTERS serial masters to NUM_SLAVES serial slaves over one shared bus.
- Grants access with rotating (round-robin) priority.
- Decodes the slave select from a serial address prefix of ADDR_BITS bits.
- Supports one split transaction: a stalled master is parked and later reconnected with priority.
- Reports out-of-range slave selects to the master as an error.

Parameters:
- NUM_MASTERS, 2, number of master ports (2..8).
- NUM_SLAVES, 3, number of slave ports (1..2^ADDR_BITS).
- ADDR_BITS, 2, serial slave-select bits, MSB first.
- SPLIT_TIMEOUT, 12, consecutive not-ready slave cycles before a split is allowed (1..255).

Ports:
- clk in 1: clock, rising edge.
- reset in 1: one clock; reset is asynchronous and active-low.
- m_request in NUM_MASTERS: per-master bus request.
- m_address_valid in NUM_MASTERS: address phase starts.
- m_address in NUM_MASTERS: serial address bit.
- m_data in NUM_MASTERS: serial write data.
- m_valid in NUM_MASTERS: bit valid on m_address/m_data.
- m_write_en in NUM_MASTERS: write enable.
- m_grant out NUM_MASTERS: one-hot, registered; master owns the bus.
- m_ready out NUM_MASTERS: s_ready of the connected slave, else 0.
- m_data_out out NUM_MASTERS: s_data_in of the connected slave, else 0.
- m_valid_in out NUM_MASTERS: s_valid_out of the connected slave, else 0.
- m_error out NUM_MASTERS: 1-cycle pulse, invalid slave select.
- s_address / s_data / s_valid / s_write_en out NUM_SLAVES: routed from the connected master, else 0.
- s_bus_ready out NUM_SLAVES: 1 when no other slave is connected.
- s_data_in / s_ready / s_valid_out in NUM_SLAVES: slave returns.
- state out 3: FSM state, for debug.
- held out 1: a split master is parked.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; m_grant, m_error, held, connection, last_grant, sel and wait_cnt all 0. All outputs 0 except s_bus_ready = all ones. Reset mid-transfer drops the connection immediately.
- State encodings: IDLE=0, ADDR=1, CONNECT=2, BUSY=3, SPLIT=4.
- IDLE:
  - Eligible masters are those with m_request & m_address_valid.
  - Winner is the first eligible index searching from last_grant+1 (wrapping).
  - Next cycle: m_grant one-hot for the winner, last_grant=winner, state -> ADDR.
  - No eligible master: stay in IDLE.
- ADDR:
  - Each cycle the granted m_valid=1, shift the granted m_address into sel, MSB first.
  - After ADDR_BITS valid bits -> CONNECT. Cycles with m_valid=0 are ignored.
  - s_valid is forced 0 in ADDR.
- CONNECT:
  - sel >= NUM_SLAVES: pulse m_error[granted] for 1 cycle, clear m_grant, -> IDLE.
  - Else s_ready[sel]=1: register connection, -> BUSY.
  - Else wait in CONNECT.
- BUSY: combinational routing both ways from the registered connection. Priority order:
  1. Granted m_request=0 and held=1: grant the held master, restore its sel, held=0, -> CONNECT. Reconnect takes precedence over round-robin.
  2. Granted m_request=0 and held=0: clear m_grant and connection, -> IDLE.
  3. wait_cnt >= SPLIT_TIMEOUT, held=0, and any other master has m_request=1 -> SPLIT.
  4. m_address_valid[granted]=1: drop the connection, -> ADDR (re-address, sel cleared).
- wait_cnt:
  - Increments in BUSY while s_ready[connected]=0, saturating at 255.
  - Cleared when s_ready=1 or on leaving BUSY.
- SPLIT:
  - Save held_master and held_sel, held=1.
  - Grant the round-robin next requester, excluding the held master, -> ADDR.
  - No other requester remains: reconnect the original master (-> CONNECT, held=0).
- Held master:
  - m_grant stays 0 while held.
  - If it drops m_request while held, held clears with no reconnect.
  - A second split while held=1 is not permitted.
- At most one m_grant bit and one connection are active at any time.
- Simultaneous requests are resolved only by round-robin order.

Test Plan:
- M0 and M1 both request with addresses 01 and 10 from reset → M0 granted first (slave 1). After M0 releases, M1 is granted (slave 2). Third round: M0 again.
- M0 sends address 11 with NUM_SLAVES=3 → m_error[0] pulses exactly 1 cycle, state returns to IDLE, no s_valid asserted.
- M0 connected to slave 0; s_ready[0]=0 for 12 cycles; M1 requesting with address 10 → SPLIT, held=1, M1 connected to slave 2. M1 releases → M0 reconnected to slave 0 within 2 cycles.
- Slave not ready at CONNECT for 5 cycles → arbiter waits; connection is made the cycle after s_ready=1; routing is verified bit-by-bit for m_data→s_data and s_data_in→m_data_out.
- reset pulsed low mid-BUSY, asynchronously between clock edges → all grants and routes go to 0 immediately; s_bus_ready=all ones; state=0.
- NUM_MASTERS=4, NUM_SLAVES=4 with all masters requesting continuously → grants rotate 0,1,2,3,0 with no starvation.
